// File: rtl/spram_seg_burst.sv
// spram_seg_burst: single-port segmented SRAM. Each request moves a burst of
// consecutive segments, advancing the segment first and then the word address.
module spram_seg_burst #(
  parameter int SEG_WIDTH     = 16,
  parameter int NUM_SEGS      = 8,
  parameter int DEPTH         = 2048,
  parameter int ADDR_WIDTH    = $clog2(DEPTH),
  parameter int SEG_SEL_WIDTH = (NUM_SEGS > 1) ? $clog2(NUM_SEGS) : 1,
  parameter int LEN_WIDTH     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_wr,
  input  logic [ADDR_WIDTH-1:0]    req_addr,
  input  logic [SEG_SEL_WIDTH-1:0] req_seg,
  input  logic [LEN_WIDTH-1:0]     req_len,
  output logic                     req_err,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [SEG_WIDTH-1:0]     wr_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [SEG_WIDTH-1:0]     rd_data,
  output logic                     rd_last,
  output logic                     busy
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] READ  = 2'd2;

  localparam int TOTAL = DEPTH * NUM_SEGS;
  localparam int IDX_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam logic [ADDR_WIDTH:0]       DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [SEG_SEL_WIDTH:0]    SEGS_LIM  = (SEG_SEL_WIDTH + 1)'(NUM_SEGS);
  localparam logic [ADDR_WIDTH-1:0]     LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [SEG_SEL_WIDTH-1:0]  LAST_SEG  = SEG_SEL_WIDTH'(NUM_SEGS - 1);

  logic [SEG_WIDTH-1:0]     mem [TOTAL];
  logic [1:0]               state;
  logic [ADDR_WIDTH-1:0]    ptr_addr, next_addr;
  logic [SEG_SEL_WIDTH-1:0] ptr_seg, next_seg;
  logic [LEN_WIDTH-1:0]     count;
  logic                     rd_pending;
  logic                     accept, bad_req, wr_fire, rd_issue, step;
  logic [IDX_W-1:0]         mem_idx;

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; a producer holds valid and its payload stable until then.
  assign req_ready = (state == IDLE);
  assign busy      = !req_ready;
  assign wr_ready  = (state == WRITE);

  assign accept   = req_valid && req_ready;
  assign bad_req  = ({1'b0, req_addr} >= DEPTH_LIM) || ({1'b0, req_seg} >= SEGS_LIM);
  assign wr_fire  = (state == WRITE) && wr_valid;
  assign rd_issue = (state == READ) && rd_pending && (!rd_valid || rd_ready);
  assign step     = wr_fire || rd_issue;
  assign mem_idx  = IDX_W'(ptr_addr) * IDX_W'(NUM_SEGS) + IDX_W'(ptr_seg);

  always_comb begin
    next_seg  = ptr_seg + SEG_SEL_WIDTH'(1);
    next_addr = ptr_addr;
    if (ptr_seg == LAST_SEG) begin
      next_seg  = '0;
      next_addr = (ptr_addr == LAST_ADDR) ? '0 : ptr_addr + ADDR_WIDTH'(1);
    end
  end

  // Storage is never reset; a reset cycle blocks any write in flight.
  always_ff @(posedge clk) begin
    if (!rst && wr_fire) mem[mem_idx] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr_addr   <= '0;
      ptr_seg    <= '0;
      count      <= '0;
      rd_pending <= 1'b0;
      req_err    <= 1'b0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
      rd_last    <= 1'b0;
    end else begin
      req_err <= accept && bad_req;
      if (step) begin
        ptr_addr <= next_addr;
        ptr_seg  <= next_seg;
        count    <= count - LEN_WIDTH'(1);
      end
      case (state)
        IDLE: begin
          if (accept && !bad_req) begin
            ptr_addr   <= req_addr;
            ptr_seg    <= req_seg;
            count      <= req_len;
            rd_pending <= !req_wr;
            state      <= req_wr ? WRITE : READ;
          end
        end
        WRITE: begin
          if (wr_fire && count == '0) state <= IDLE;
        end
        READ: begin
          if (rd_issue) begin
            rd_data  <= mem[mem_idx];
            rd_valid <= 1'b1;
            rd_last  <= (count == '0);
            if (count == '0) rd_pending <= 1'b0;
          end else if (rd_valid && rd_ready) begin
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
          end
          if (rd_valid && rd_ready && rd_last) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spram_seg_burst.sv
// Bench for spram_seg_burst: directed scenarios plus random bursts, checked
// against a flat segment-array model addressed as word*NUM_SEGS+seg.
module tb_spram_seg_burst;
  localparam int SW    = 16;
  localparam int NS    = 8;
  localparam int DP    = 20;
  localparam int AW    = 5;
  localparam int SSW   = 3;
  localparam int LW    = 8;
  localparam int TOTAL = DP * NS;

  logic clk = 1'b0;
  logic rst;
  logic req_valid, req_ready, req_wr, req_err;
  logic [AW-1:0]  req_addr;
  logic [SSW-1:0] req_seg;
  logic [LW-1:0]  req_len;
  logic wr_valid, wr_ready;
  logic [SW-1:0] wr_data;
  logic rd_valid, rd_ready, rd_last, busy;
  logic [SW-1:0] rd_data;

  logic [SW-1:0] model [TOTAL];
  logic [SW-1:0] wdata_q[$];
  logic [SW-1:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  spram_seg_burst #(
    .SEG_WIDTH(SW), .NUM_SEGS(NS), .DEPTH(DP), .ADDR_WIDTH(AW),
    .SEG_SEL_WIDTH(SSW), .LEN_WIDTH(LW)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_seg(req_seg), .req_len(req_len), .req_err(req_err),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Drives one request; returns at the falling edge right after the accept edge.
  task automatic send_req(input bit wr, input int addr, input int seg, input int len,
                          input bit expect_err);
    @(negedge clk);
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL req_ready_idle: got %b, expected 1", req_ready);
    end
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = AW'(addr);
    req_seg   = SSW'(seg);
    req_len   = LW'(len);
    @(negedge clk);
    req_valid = 1'b0;
    vectors++;
    if (req_err !== expect_err) begin
      miscompares++;
      $display("FAIL req_err: got %b, expected %b", req_err, expect_err);
    end
  endtask

  // Writes nbeats segments popped from wdata_q, optionally with idle gaps.
  task automatic do_write(input int addr, input int seg, input int len, input int nbeats,
                          input bit gaps);
    int base, sent, cyc;
    bit fire;
    base = addr * NS + seg;
    send_req(1'b1, addr, seg, len, 1'b0);
    vectors++;
    if (wr_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL wr_ready_start: got %b, expected 1", wr_ready);
    end
    sent = 0;
    cyc  = 0;
    while (sent < nbeats && cyc < 1000) begin
      if (gaps && $urandom_range(0, 3) == 0) wr_valid = 1'b0;
      else begin
        wr_valid = 1'b1;
        wr_data  = wdata_q[0];
      end
      fire = wr_valid && (wr_ready === 1'b1);
      @(negedge clk);
      if (fire) begin
        model[(base + sent) % TOTAL] = wdata_q.pop_front();
        sent++;
      end
      cyc++;
    end
    wr_valid = 1'b0;
    if (sent < nbeats) begin
      vectors++;
      miscompares++;
      $display("FAIL wr_timeout: got %0d beats, expected %0d", sent, nbeats);
    end
    if (nbeats == len + 1) begin
      vectors++;
      if (busy !== 1'b0) begin
        miscompares++;
        $display("FAIL wr_done_idle: busy %b, expected 0", busy);
      end
    end
  endtask

  // mode 0: rd_ready held high, 1: pattern 1,0,0 repeating, 2: random.
  task automatic do_read(input int addr, input int seg, input int len, input int mode);
    int n, base, got, k, pcnt;
    bit stalled, held_last, want_last;
    logic [SW-1:0] held, exp;
    n = len + 1;
    base = addr * NS + seg;
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(model[(base + i) % TOTAL]);
    send_req(1'b0, addr, seg, len, 1'b0);
    vectors++;
    if (rd_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rd_valid_early: got %b, expected 0", rd_valid);
    end
    got = 0; k = 1; pcnt = 0; stalled = 1'b0; held = '0; held_last = 1'b0;
    while (got < n && k < 2000) begin
      if (stalled) begin
        vectors++;
        if (rd_valid !== 1'b1 || rd_data !== held || rd_last !== held_last) begin
          miscompares++;
          $display("FAIL rd_hold: valid %b data %h last %b, expected 1 %h %b",
                   rd_valid, rd_data, rd_last, held, held_last);
        end
      end
      case (mode)
        0:       rd_ready = 1'b1;
        1:       rd_ready = (pcnt % 3 == 0);
        default: rd_ready = ($urandom_range(0, 1) == 1);
      endcase
      pcnt++;
      if (rd_valid === 1'b1 && rd_ready) begin
        exp = exp_q.pop_front();
        want_last = (got == n - 1);
        vectors++;
        if (rd_data !== exp || rd_last !== want_last) begin
          miscompares++;
          $display("FAIL rd_beat %0d: data %h last %b, expected %h last %b",
                   got, rd_data, rd_last, exp, want_last);
        end
        got++;
        stalled = 1'b0;
        if (got == n && mode == 0) begin
          vectors++;
          if (k != n + 1) begin
            miscompares++;
            $display("FAIL rd_latency: last handshake after %0d cycles, expected %0d", k, n + 1);
          end
        end
      end else begin
        stalled   = (rd_valid === 1'b1);
        held      = rd_data;
        held_last = rd_last;
      end
      @(negedge clk);
      k++;
    end
    rd_ready = 1'b0;
    if (got < n) begin
      vectors++;
      miscompares++;
      $display("FAIL rd_timeout: got %0d beats, expected %0d", got, n);
    end
    vectors++;
    if (req_ready !== 1'b1 || rd_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rd_done_idle: req_ready %b rd_valid %b, expected 1 0", req_ready, rd_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({req_ready, req_err, wr_ready, rd_valid, rd_last, busy} !== 6'b100000) begin
      miscompares++;
      $display("FAIL reset_ctrl: rdy/err/wrr/rdv/last/busy %b, expected 100000",
               {req_ready, req_err, wr_ready, rd_valid, rd_last, busy});
    end
    vectors++;
    if (rd_data !== '0) begin
      miscompares++;
      $display("FAIL reset_rd_data: got %h, expected 0000", rd_data);
    end
    rst = 1'b0;
  endtask

  task automatic test_fill();
    for (int i = 0; i < TOTAL; i++) wdata_q.push_back('0);
    do_write(0, 0, TOTAL - 1, TOTAL, 1'b0);
  endtask

  task automatic test_single();
    wdata_q.push_back(16'hBEEF);
    do_write(5, 3, 0, 1, 1'b0);
    do_read(5, 3, 0, 0);
    do_read(5, 0, NS - 1, 0);
  endtask

  task automatic test_word_cross();
    wdata_q.push_back(16'h1111);
    wdata_q.push_back(16'h2222);
    wdata_q.push_back(16'h3333);
    wdata_q.push_back(16'h4444);
    do_write(10, 6, 3, 4, 1'b0);
    do_read(10, 6, 3, 0);
    do_read(11, 0, 0, 0);
  endtask

  task automatic test_addr_wrap();
    wdata_q.push_back(16'hA001);
    wdata_q.push_back(16'hA002);
    do_write(DP - 1, NS - 1, 1, 2, 1'b0);
    do_read(DP - 1, NS - 1, 1, 0);
    do_read(0, 0, 0, 0);
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 8; i++) wdata_q.push_back(16'h7000 + SW'(i));
    do_write(2, 4, 7, 8, 1'b0);
    do_read(2, 4, 7, 1);
  endtask

  task automatic test_reject();
    wr_valid = 1'b1;
    wr_data  = 16'hDEAD;
    send_req(1'b1, DP, 0, 3, 1'b1);
    vectors++;
    if (busy !== 1'b0 || wr_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reject_busy: busy %b wr_ready %b, expected 0 0", busy, wr_ready);
    end
    @(negedge clk);
    vectors++;
    if (req_err !== 1'b0 || req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reject_pulse: req_err %b req_ready %b, expected 0 1", req_err, req_ready);
    end
    wr_valid = 1'b0;
    send_req(1'b0, 31, 5, 0, 1'b1);
    repeat (2) begin
      @(negedge clk);
      vectors++;
      if (rd_valid !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL reject_read: rd_valid %b busy %b, expected 0 0", rd_valid, busy);
      end
    end
    do_read(0, 0, TOTAL - 1, 2);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) wdata_q.push_back(16'hC000 + SW'(i));
    do_write(3, 2, 4, 2, 1'b0);
    wdata_q.delete();
    wr_valid = 1'b1;
    wr_data  = 16'h5A5A;
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (req_ready !== 1'b1 || wr_ready !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_wr: req_ready %b wr_ready %b busy %b, expected 1 0 0",
               req_ready, wr_ready, busy);
    end
    rst = 1'b0;
    wr_valid = 1'b0;
    do_read(3, 2, 4, 0);
    send_req(1'b0, 0, 0, 9, 1'b0);
    rd_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (rd_valid !== 1'b0 || req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid_rd: rd_valid %b req_ready %b, expected 0 1", rd_valid, req_ready);
    end
    rst = 1'b0;
  endtask

  task automatic test_random();
    int a, s, l;
    for (int it = 0; it < 30; it++) begin
      a = $urandom_range(0, DP - 1);
      s = $urandom_range(0, NS - 1);
      l = $urandom_range(0, 40);
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i <= l; i++) wdata_q.push_back(SW'($urandom));
        do_write(a, s, l, l + 1, 1'b1);
      end else begin
        do_read(a, s, l, 2);
      end
    end
    do_read(0, 0, TOTAL - 1, 0);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_seg = '0; req_len = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    test_reset();
    test_fill();
    test_single();
    test_word_cross();
    test_addr_wrap();
    test_backpressure();
    test_reject();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/spram_seg_burst.md
# spram_seg_burst

Parametrised single-port segmented SRAM with burst access and valid/ready handshakes. It is the next-generation version of the 128-bit segmented scan-chain RAM. Word width, segment width, segment count and depth are now parameters. One request transfers a burst of consecutive segments, auto-incrementing segment then word. It sits behind the scan-chain / SIMD accelerator load path, which streams operand vectors in and out one segment per cycle.

## Interface
Parameters:
- SEG_WIDTH, 16, width of one segment (data beat)
- NUM_SEGS, 8, segments per word; word width = SEG_WIDTH*NUM_SEGS
- DEPTH, 2048, number of words; need not be a power of two
- ADDR_WIDTH, $clog2(DEPTH), word address width
- SEG_SEL_WIDTH, $clog2(NUM_SEGS) (minimum 1), segment select width
- LEN_WIDTH, 8, burst length field width; maximum burst is 2^LEN_WIDTH segments

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block idle and accepting a request
- req_wr  in  1  1 = write burst, 0 = read burst
- req_addr  in  ADDR_WIDTH  start word address
- req_seg  in  SEG_SEL_WIDTH  start segment within the word
- req_len  in  LEN_WIDTH  burst length minus one (0 = 1 segment)
- req_err  out  1  one-cycle pulse: the request was rejected
- wr_valid  in  1  write beat present
- wr_ready  out  1  write beat accepted
- wr_data  in  SEG_WIDTH  write segment
- rd_valid  out  1  read beat present
- rd_ready  in  1  consumer takes the read beat
- rd_data  out  SEG_WIDTH  read segment
- rd_last  out  1  qualifies the final beat of the burst
- busy  out  1  state != IDLE

## Operation
- Storage is DEPTH words of NUM_SEGS segments. Contents are not cleared by rst and are undefined until written.
- FSM states are IDLE, WRITE and READ. req_ready = (state == IDLE) and busy = !req_ready.
- A request is accepted when req_valid && req_ready.
- Rejection: if req_addr >= DEPTH or req_seg >= NUM_SEGS, the request is accepted, req_err pulses, the FSM stays IDLE and no memory access occurs.
- On a valid accept, the block latches the pointer (addr, seg) and the remaining count = req_len. It moves to WRITE or READ according to req_wr.
- Pointer advance after each beat:
  - seg increments.
  - When seg == NUM_SEGS-1, seg becomes 0 and addr increments.
  - When addr == DEPTH-1 and seg wraps, addr becomes 0.
  - Wrap-around is silent; it is not an error.
- WRITE state:
  - wr_ready = 1.
  - Each wr_valid beat writes wr_data into segment [seg] of word [addr]. Only that segment changes.
  - On the beat with count == 0, the FSM returns to IDLE. Otherwise count decrements.
- READ state:
  - The block issues a read when (!rd_valid || rd_ready) and beats remain to issue.
  - The read is registered: rd_data, rd_valid and rd_last update on the next edge.
  - rd_last = 1 on the beat issued when count == 0.
  - Output holds stable while rd_valid && !rd_ready.
  - The FSM returns to IDLE on the cycle after the rd_valid && rd_ready && rd_last handshake.
- wr_valid is ignored outside WRITE, and wr_ready = 0 there. rd_ready is ignored when rd_valid = 0.
- Reset mid-burst:
  - The next state is IDLE, and the count and pointer are discarded.
  - Segments already written stay written.
  - rd_valid is dropped and no further write occurs.

## Timing
- Reset values: req_ready = 1, req_err = 0, wr_ready = 0, rd_valid = 0, rd_data = 0, rd_last = 0, busy = 0.
- Request accepted at edge T:
  - WRITE: wr_ready = 1 from cycle T+1; the first beat can be written at edge T+1.
  - READ: the first read is issued in cycle T+1; rd_valid = 1 from cycle T+2.
- Throughput is one segment per cycle in both directions when wr_valid / rd_ready are held high.
- An N-beat read with rd_ready held at 1 takes:
  - accept,
  - then N+1 cycles until the last handshake,
  - then req_ready = 1 one cycle later.
- Read-after-write: a read issued any cycle after the last write edge returns the new data.
- req_err is high for exactly the one cycle after the rejected accept edge. req_ready stays 1 throughout.

## Test plan
- Single write then read: write req (addr=5, seg=3, len=0, data 0xBEEF), then read req (addr=5, seg=3, len=0) -> rd_data = 0xBEEF with rd_last = 1. The other 7 segments of word 5 are unchanged from a prior fill of 0x0000.
- Word-crossing burst: write addr=10, seg=6, len=3, data 0x1111..0x4444 -> word10 seg6 = 0x1111, word10 seg7 = 0x2222, word11 seg0 = 0x3333, word11 seg1 = 0x4444. A 4-beat read returns the same sequence, with rd_last only on 0x4444.
- Address wrap: write addr=DEPTH-1, seg=7, len=1 -> second beat lands at word 0 seg 0. No req_err.
- Backpressure: 8-beat read with rd_ready toggling 1,0,0,1,… -> rd_data holds while stalled, no beat is lost or duplicated, and order is preserved.
- Rejection: req addr=DEPTH (or seg=NUM_SEGS when NUM_SEGS is not a power of two) -> req_err pulses 1 cycle, busy stays 0, and memory is unchanged.
- Reset mid-burst: assert rst after 2 of 5 write beats -> next cycle req_ready = 1 and wr_ready = 0. The 2 written segments read back correctly and the remaining 3 segments are unchanged.
